// File: rtl/ibex_mprf_msg_loader_if.sv
// Loader bus bundle: upstream message beats, MPRF input write port,
// completion notices to the core, slot release and status.
//  slave  : loader side (drives ready, MPRF write, notices, free count, err)
//  master : environment side (drives beats, core write flag, pops, releases)
interface ibex_mprf_msg_loader_if #(
  parameter int DataWidth = 32
);
  logic                 msg_valid_i;
  logic                 msg_ready_o;
  logic [DataWidth-1:0] msg_data_i;
  logic [1:0]           msg_len_i;
  logic                 core_mprf_we_i;
  logic                 mprf_we_o;
  logic [4:0]           mprf_addr_o;
  logic [DataWidth-1:0] mprf_wdata_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic [4:0]           rx_base_o;
  logic [1:0]           rx_len_o;
  logic                 rel_valid_i;
  logic [2:0]           rel_slot_i;
  logic [2:0]           free_cnt_o;
  logic                 err_o;

  modport slave (
    input  msg_valid_i, msg_data_i, msg_len_i,
    input  core_mprf_we_i, rx_ready_i,
    input  rel_valid_i, rel_slot_i,
    output msg_ready_o, mprf_we_o,
    output mprf_addr_o, mprf_wdata_o,
    output rx_valid_o, rx_base_o, rx_len_o,
    output free_cnt_o, err_o
  );

  modport master (
    output msg_valid_i, msg_data_i, msg_len_i,
    output core_mprf_we_i, rx_ready_i,
    output rel_valid_i, rel_slot_i,
    input  msg_ready_o, mprf_we_o,
    input  mprf_addr_o, mprf_wdata_o,
    input  rx_valid_o, rx_base_o, rx_len_o,
    input  free_cnt_o, err_o
  );
endinterface

// File: rtl/ibex_mprf_msg_loader.sv
// Loads inbound multi-word messages into 4-word MPRF slots, queues
// completion notices and reclaims slots on core release.
//  clk_i, rst_ni : clock, async active-low reset
//  bus (slave)   : beats in, MPRF write out, notices out, release in
module ibex_mprf_msg_loader #(
  parameter int DataWidth = 32,
  parameter int NumSlots  = 7
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  ibex_mprf_msg_loader_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_QUEUED = 2'd2;
  localparam logic [1:0] S_OWNED  = 2'd3;

  localparam logic [2:0] LastIdx = 3'(NumSlots - 1);
  localparam logic [3:0] NumW    = 4'(NumSlots);

  logic [0:0]      state_q, state_d;
  logic [2:0]      slot_q, slot_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0][1:0] st_q, st_d;
  logic [7:0][2:0] fslot_q, fslot_d;
  logic [7:0][1:0] flen_q, flen_d;
  logic [2:0]      wr_ptr_q, wr_ptr_d;
  logic [2:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [2:0]           free_cnt;
  logic [2:0]           alloc_slot;
  logic [2:0]           cur_slot;
  logic [1:0]           cur_idx;
  logic [1:0]           push_len;
  logic                 ready;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 rel_ok;
  logic [DataWidth-1:0] wdata;

  function automatic logic [2:0] nxt(input logic [2:0] p);
    return (p == LastIdx) ? 3'd0 : p + 3'd1;
  endfunction

  // Downward scan leaves the lowest free index in alloc_slot.
  always_comb begin
    free_cnt   = '0;
    alloc_slot = '0;
    for (int k = NumSlots - 1; k >= 0; k--) begin
      if (st_q[3'(k)] == S_FREE) begin
        free_cnt   = free_cnt + 3'd1;
        alloc_slot = 3'(k);
      end
    end
  end

  assign ready = !bus.core_mprf_we_i &
                 ((state_q == FILL) | (free_cnt != 3'd0));
  assign accept = bus.msg_valid_i & ready;

  // The first beat lands at word 0 of the slot it allocates.
  assign cur_slot = (state_q == IDLE) ? alloc_slot : slot_q;
  assign cur_idx  = (state_q == IDLE) ? 2'd0 : idx_q;
  assign push_len = (state_q == IDLE) ? bus.msg_len_i : len_q;
  assign push     = accept & (cur_idx == push_len);
  assign pop      = (cnt_q != 3'd0) & bus.rx_ready_i;

  // Checked against pre-pop state: a slot popped this cycle
  // is still QUEUED, so releasing it is rejected.
  assign rel_ok = bus.rel_valid_i &
                  ({1'b0, bus.rel_slot_i} < NumW) &
                  (st_q[bus.rel_slot_i] == S_OWNED);

  assign wdata = accept ? bus.msg_data_i : '0;

  assign bus.msg_ready_o  = ready;
  assign bus.mprf_we_o    = accept;
  assign bus.mprf_addr_o  = accept ? {cur_slot + 3'd1, cur_idx} : '0;
  assign bus.mprf_wdata_o = wdata;
  assign bus.rx_valid_o   = cnt_q != 3'd0;
  assign bus.rx_base_o    = {fslot_q[rd_ptr_q] + 3'd1, 2'b00};
  assign bus.rx_len_o     = flen_q[rd_ptr_q];
  assign bus.free_cnt_o   = free_cnt;
  assign bus.err_o        = err_q;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    len_d    = len_q;
    idx_d    = idx_q;
    st_d     = st_q;
    fslot_d  = fslot_q;
    flen_d   = flen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = bus.rel_valid_i & !rel_ok;
    if (accept) begin
      if (state_q == IDLE) begin
        slot_d           = alloc_slot;
        len_d            = bus.msg_len_i;
        st_d[alloc_slot] = S_FILL;
      end
      idx_d   = cur_idx + 2'd1;
      state_d = FILL;
      if (push) begin
        state_d           = IDLE;
        st_d[cur_slot]    = S_QUEUED;
        fslot_d[wr_ptr_q] = cur_slot;
        flen_d[wr_ptr_q]  = push_len;
        wr_ptr_d          = nxt(wr_ptr_q);
      end
    end
    if (pop) begin
      st_d[fslot_q[rd_ptr_q]] = S_OWNED;
      rd_ptr_d                = nxt(rd_ptr_q);
    end
    if (rel_ok) begin
      st_d[bus.rel_slot_i] = S_FREE;
    end
    cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      st_q     <= '0;
      fslot_q  <= '0;
      flen_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      st_q     <= st_d;
      fslot_q  <= fslot_d;
      flen_q   <= flen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule
